// File: rtl/ifq.sv
// rtl/ifq.sv - instruction fetch queue: 128-bit icache lines in, one FWFT instruction per cycle to dispatch
// Define IFQ_BYPASS_EN to present a returning line to dispatch in the same cycle when the queue is empty.
module ifq #(
  parameter int          DEPTH_LINES = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  output logic         icache_rd_en,
  output logic [31:0]  icache_addr,
  input  logic [127:0] icache_dout,
  input  logic         icache_dout_valid,
  output logic [31:0]  dispatch_inst,
  output logic [31:0]  dispatch_pc_out,
  output logic         dispatch_empty,
  input  logic         dispatch_rd_en,
  input  logic [31:0]  dispatch_jump_branch_addr,
  input  logic         dispatch_jump_branch_valid
);

  localparam int         LW      = $clog2(DEPTH_LINES);
  localparam logic [LW:0] PTR_ONE = (LW+1)'(1);

  logic [127:0] mem [DEPTH_LINES];
  logic [LW:0]  wr_ptr;
  logic [LW:0]  rd_line;
  logic [1:0]   rd_off;
  logic [31:0]  head_pc;
  logic [31:0]  fetch_pc;
  logic         outstanding;
  logic         discard;

  logic         queue_empty;
  logic         queue_full;
  logic         redirect;
  logic         issue;
  logic         accept;
  logic         pop;
  logic         bypass_hit;
  logic [127:0] head_line;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^dispatch_jump_branch_addr[1:0];

  assign redirect    = dispatch_jump_branch_valid;
  assign queue_empty = (wr_ptr == rd_line);
  // A partially consumed line still holds its slot until its last word pops.
  assign queue_full  = (wr_ptr[LW] != rd_line[LW]) && (wr_ptr[LW-1:0] == rd_line[LW-1:0]);

  assign issue  = rst && !outstanding && !icache_dout_valid && !queue_full && !redirect;
  // Data with nothing outstanding belongs to a request abandoned by reset.
  assign accept = icache_dout_valid && outstanding && !discard && !redirect;

  assign icache_rd_en = issue;
  assign icache_addr  = issue ? fetch_pc : 32'h0;

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = queue_empty && icache_dout_valid && outstanding && !discard;
`else
  assign bypass_hit = 1'b0;
`endif

  assign head_line      = bypass_hit ? icache_dout : mem[rd_line[LW-1:0]];
  assign dispatch_empty = queue_empty && !bypass_hit;
  assign dispatch_pc_out = head_pc + 32'd4;
  assign pop            = dispatch_rd_en && !dispatch_empty && !redirect;

  always_comb begin
    dispatch_inst = head_line[31:0];
    case (rd_off)
      2'd0: dispatch_inst = head_line[31:0];
      2'd1: dispatch_inst = head_line[63:32];
      2'd2: dispatch_inst = head_line[95:64];
      2'd3: dispatch_inst = head_line[127:96];
      default: dispatch_inst = head_line[31:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_line     <= '0;
      rd_off      <= 2'd0;
      head_pc     <= RESET_PC;
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      for (int i = 0; i < DEPTH_LINES; i++) begin
        mem[i] <= '0;
      end
    end else if (redirect) begin
      head_pc     <= {dispatch_jump_branch_addr[31:2], 2'b00};
      fetch_pc    <= {dispatch_jump_branch_addr[31:4], 4'h0};
      rd_off      <= dispatch_jump_branch_addr[3:2];
      rd_line     <= wr_ptr;
      // A line returning this cycle is dropped; one still in flight gets dropped later.
      outstanding <= outstanding && !icache_dout_valid;
      discard     <= outstanding && !icache_dout_valid;
    end else begin
      if (pop) begin
        rd_off  <= rd_off + 2'd1;
        head_pc <= head_pc + 32'd4;
        if (rd_off == 2'd3) begin
          rd_line <= rd_line + PTR_ONE;
        end
      end
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd16;
        outstanding <= 1'b1;
      end else if (icache_dout_valid) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
        if (accept) begin
          mem[wr_ptr[LW-1:0]] <= icache_dout;
          wr_ptr              <= wr_ptr + PTR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifq.sv
// tb/tb_ifq.sv - self-checking bench for ifq: icache responder, request log and word scoreboard
module tb_ifq;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_rd_en;
  logic [31:0]  icache_addr;
  logic [127:0] icache_dout;
  logic         icache_dout_valid;
  logic [31:0]  dispatch_inst;
  logic [31:0]  dispatch_pc_out;
  logic         dispatch_empty;
  logic         dispatch_rd_en;
  logic [31:0]  jb_addr;
  logic         jb_valid;

  always #5 clk = ~clk;

  ifq #(.DEPTH_LINES(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .icache_rd_en(icache_rd_en), .icache_addr(icache_addr),
    .icache_dout(icache_dout), .icache_dout_valid(icache_dout_valid),
    .dispatch_inst(dispatch_inst), .dispatch_pc_out(dispatch_pc_out),
    .dispatch_empty(dispatch_empty), .dispatch_rd_en(dispatch_rd_en),
    .dispatch_jump_branch_addr(jb_addr), .dispatch_jump_branch_valid(jb_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 2;
  int c0, t, r, idx, last_pop_cyc;
  bit found;

  int          due_cyc_q[$];
  logic [31:0] due_addr_q[$];
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [31:0] sb[$];

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_req;
    logic [31:0] exp_head;
    int          n;
  } redir_t;
  redir_t vec[4];

  function automatic logic [127:0] line_of(logic [31:0] a);
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  // Memory model: word value equals its address; responses come lat cycles after the request.
  initial begin
    icache_dout_valid = 1'b0;
    icache_dout = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (due_cyc_q.size() > 0 && due_cyc_q[0] <= cyc) begin
        icache_dout_valid = 1'b1;
        icache_dout = line_of(due_addr_q[0]);
        void'(due_cyc_q.pop_front());
        void'(due_addr_q.pop_front());
      end else begin
        icache_dout_valid = 1'b0;
      end
      #3;
      if (icache_rd_en === 1'b1) begin
        due_cyc_q.push_back(cyc + lat);
        due_addr_q.push_back(icache_addr);
        req_addr_q.push_back(icache_addr);
        req_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int find_req_after(int tc);
    for (int i = 0; i < req_cyc_q.size(); i++) begin
      if (req_cyc_q[i] > tc) return i;
    end
    return -1;
  endfunction

  task automatic check_req(string name, int i, logic [31:0] exp_addr, int exp_cyc);
    if (i < 0 || i >= req_addr_q.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: request %0d missing, got %0d requests", name, i, req_addr_q.size());
    end else begin
      check({name, "_addr"}, req_addr_q[i], exp_addr);
      if (exp_cyc >= 0) check({name, "_cyc"}, 32'(req_cyc_q[i]), 32'(exp_cyc));
    end
  endtask

  task automatic pop_n(int n, string tag);
    for (int i = 0; i < n; i++) begin
      int w;
      logic [31:0] exp;
      w = 0;
      while (dispatch_empty && w < 30) begin
        step();
        w++;
      end
      if (dispatch_empty) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for word %0d, got empty, expected data", tag, i);
        return;
      end
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: scoreboard underflow at word %0d, got %h, expected none", tag, i, dispatch_inst);
        return;
      end
      exp = sb.pop_front();
      check({tag, "_inst"}, dispatch_inst, exp);
      check({tag, "_pc_out"}, dispatch_pc_out, exp + 32'd4);
      dispatch_rd_en = 1'b1;
      last_pop_cyc = cyc;
      step();
      dispatch_rd_en = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    dispatch_rd_en = 1'b0;
    jb_valid = 1'b0;
    jb_addr = 32'h0;
    step();
    due_cyc_q.delete();
    due_addr_q.delete();
    step();
    req_addr_q.delete();
    req_cyc_q.delete();
    sb.delete();
    rst = 1'b1;
    c0 = cyc;
  endtask

  initial begin
    vec[0] = '{32'h0000_1008, 32'h0000_1000, 32'h0000_1008, 2};
    vec[1] = '{32'h0000_2000, 32'h0000_2000, 32'h0000_2000, 4};
    vec[2] = '{32'h0000_300F, 32'h0000_3000, 32'h0000_300C, 1};
    vec[3] = '{32'hFFFF_FFF4, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 3};

    rst = 1'b0;
    dispatch_rd_en = 1'b0;
    jb_valid = 1'b0;
    jb_addr = 32'h0;
    repeat (3) step();
    check("reset_rd_en", 32'(icache_rd_en), 32'h0);
    check("reset_addr", icache_addr, 32'h0);
    check("reset_empty", 32'(dispatch_empty), 32'h1);
    check("reset_inst", dispatch_inst, 32'h0);
    check("reset_pc_out", dispatch_pc_out, 32'h4);

    // Sequential fetch, latency 2.
    lat = 2;
    do_reset();
    step();
    check("t1_empty_r1", 32'(dispatch_empty), 32'h1);
    step();
`ifdef IFQ_BYPASS_EN
    check("t1_bypass_empty", 32'(dispatch_empty), 32'h0);
    check("t1_bypass_inst", dispatch_inst, 32'h0);
`else
    check("t1_empty_r2", 32'(dispatch_empty), 32'h1);
`endif
    step();
    check("t1_empty_r3", 32'(dispatch_empty), 32'h0);
    check_req("t1_req0", 0, 32'h0, c0);
    for (int k = 0; k < 4; k++) sb.push_back(32'(4 * k));
    pop_n(4, "t1");
    check_req("t1_req1", 1, 32'h10, c0 + 3);

    // Full stall, then one freed slot.
    do_reset();
    repeat (40) step();
    check("t2_req_count", 32'(req_addr_q.size()), 32'(DEPTH));
    for (int k = 0; k < DEPTH; k++) check_req("t2_req", k, 32'(16 * k), -1);
    for (int k = 0; k < 4; k++) sb.push_back(32'(4 * k));
    pop_n(4, "t2");
    #2;
    check_req("t2_req_after_free", DEPTH, 32'h40, last_pop_cyc + 1);
    repeat (20) step();
    check("t2_req_count_final", 32'(req_addr_q.size()), 32'(DEPTH + 1));

    // Redirect vectors applied back to back on a running queue.
    do_reset();
    repeat (3) step();
    for (int v = 0; v < 4; v++) begin
      jb_addr = vec[v].target;
      jb_valid = 1'b1;
      t = cyc;
      step();
      jb_valid = 1'b0;
      check("t3_empty_after_redirect", 32'(dispatch_empty), 32'h1);
      sb.delete();
      for (int k = 0; k < vec[v].n; k++) sb.push_back(vec[v].exp_head + 32'(4 * k));
      sb.push_back(vec[v].exp_req + 32'd16);
      pop_n(vec[v].n + 1, "t3");
      idx = find_req_after(t);
      check_req("t3_first_req", idx, vec[v].exp_req, -1);
      if (idx >= 0) check_req("t3_second_req", idx + 1, vec[v].exp_req + 32'd16, -1);
    end

    // Redirect while a request is in flight, latency 3.
    lat = 3;
    do_reset();
    for (int k = 0; k < 4; k++) sb.push_back(32'(4 * k));
    pop_n(4, "t4_pre");
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      #2;
      if (icache_rd_en === 1'b1 && icache_addr == 32'h40) begin
        found = 1'b1;
        r = cyc;
        break;
      end
      step();
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL t4_find_req40: got no request, expected request at 00000040");
    end else begin
      step();
      jb_addr = 32'h200;
      jb_valid = 1'b1;
      step();
      jb_valid = 1'b0;
      check("t4_empty_after_redirect", 32'(dispatch_empty), 32'h1);
      sb.delete();
      sb.push_back(32'h200);
      sb.push_back(32'h204);
      pop_n(2, "t4");
      check_req("t4_req_after_drop", find_req_after(r), 32'h200, r + 4);
    end

    // Redirect, pop and returning line in the same cycle; pops while empty.
    lat = 2;
    do_reset();
    repeat (5) step();
    check("t5_setup_dout_valid", 32'(icache_dout_valid), 32'h1);
    jb_addr = 32'h500;
    jb_valid = 1'b1;
    dispatch_rd_en = 1'b1;
    t = cyc;
    step();
    jb_valid = 1'b0;
    check("t5_empty_t1", 32'(dispatch_empty), 32'h1);
    step();
    check("t5_empty_t2", 32'(dispatch_empty), 32'h1);
    dispatch_rd_en = 1'b0;
    for (int k = 0; k < 5; k++) sb.push_back(32'h500 + 32'(4 * k));
    pop_n(5, "t5");
    check_req("t5_req_redirect", find_req_after(t - 1), 32'h500, t + 1);

    // Reset while a line is in flight: the stale return must be dropped.
    lat = 3;
    do_reset();
    step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    check("t6_empty_stale_cycle", 32'(dispatch_empty), 32'h1);
    step();
    check("t6_empty_after_stale", 32'(dispatch_empty), 32'h1);
    #2;
    check_req("t6_reissue", 1, 32'h0, c0 + 4);
    sb.delete();
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    pop_n(2, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifq.md
# ifq

Instruction fetch queue sitting directly upstream of `dispatch`. It fetches 128-bit (4-instruction) lines from the instruction cache and buffers them. It presents one instruction per cycle, plus its PC+4, to dispatch through a first-word-fall-through interface. On a jump/branch redirect from dispatch it flushes all buffered and in-flight instructions and restarts fetch at the target.

## Interface

**Parameters**
- `DEPTH_LINES`, default 4: number of 128-bit line slots. Power of two, ≥2.
- `RESET_PC`, default 32'h0000_0000: first fetch address. Must be 16-byte aligned.

**Ports**
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-low reset (asserted when 0, sampled on `clk`).
- `icache_rd_en` output 1: one-cycle line read request.
- `icache_addr` output 32: request address; bits [3:0] always 0.
- `icache_dout` input 128: returned line; word 0 in [31:0], word 3 in [127:96].
- `icache_dout_valid` input 1: `icache_dout` valid this cycle. Arrives ≥1 cycle after its request, in order.
- `dispatch_inst` output 32: head instruction.
- `dispatch_pc_out` output 32: head instruction address + 4.
- `dispatch_empty` output 1: no valid instruction at head.
- `dispatch_rd_en` input 1: pop head this cycle. Ignored when `dispatch_empty`=1.
- `dispatch_jump_branch_addr` input 32: redirect target; bits [1:0] ignored.
- `dispatch_jump_branch_valid` input 1: one-cycle redirect strobe.

## Operation

**Storage**
- `DEPTH_LINES` × 128-bit slots, cleared to 0 on reset.
- Write pointer is line-granular, with a wrap bit.
- Read pointer is word-granular (`{line, offset[1:0]}`), with a wrap bit.
- `head_pc` register tracks the address of the head word.

**Fetch control**
- State: `fetch_pc`, `outstanding` (1 bit), `discard` (1 bit). At most one request is in flight.
- A request is issued when `outstanding`=0, `icache_dout_valid`=0, and occupied slots < `DEPTH_LINES`. A slot holding a partially consumed line counts as occupied.
- On issue: `icache_addr`=`fetch_pc`, `icache_rd_en`=1 for exactly one cycle. The next cycle, `fetch_pc` += 16 and `outstanding`=1.
- On `icache_dout_valid` with `discard`=0: line written at the write pointer, write pointer advances, `outstanding` clears.
- On `icache_dout_valid` with `discard`=1: line dropped, both `discard` and `outstanding` clear.

**Read**
- `dispatch_inst` = word at the read pointer, combinational from storage.
- `dispatch_pc_out` = `head_pc` + 4, modulo 2^32.
- On a pop: offset increments and `head_pc` += 4. When offset wraps 3→0, the line pointer advances and the slot is freed.

**Redirect** (`dispatch_jump_branch_valid`=1 in cycle T)
- The queue becomes empty at T+1.
- `head_pc` ← target & ~3.
- `fetch_pc` ← target & ~15.
- Read offset ← target[3:2], so leading words of the first fetched line are skipped.
- Write and read line pointers are equalised.
- If a request is still outstanding after T, `discard` ← 1.
- A line returning in cycle T itself is dropped.
- No request is issued in cycle T; the first new request goes out at T+1 at the earliest.

**Priority:** redirect > pop > write. A `dispatch_rd_en` coinciding with a redirect is ignored.

**Reset outputs**
- `icache_rd_en`=0, `icache_addr`=0.
- `dispatch_empty`=1, `dispatch_inst`=0, `dispatch_pc_out`=`RESET_PC`+4.
- `fetch_pc`=`RESET_PC`, `outstanding`=0, `discard`=0.
- Reset mid-operation abandons any in-flight line: the first `icache_dout_valid` after reset release, if no request has been issued since, is dropped.

## Timing

- First request is issued in the first cycle with `rst`=1.
- Request in cycle R, data valid in cycle R+L (L≥1). The line is written at the end of R+L; `dispatch_empty` falls in R+L+1 (non-bypass build).
- The next request can issue at R+L+1 at the earliest. Sustained fetch is 4 words per L+1 cycles.
- A pop in cycle P makes the next word visible in P+1. Back-to-back pops are allowed at one per cycle.
- When the queue is full (all slots occupied), fetching stalls until a line is freed. The request issues in the cycle after the freeing pop.
- `dispatch_empty` is registered state, except in the bypass case below.

## Configuration

- Macro: `IFQ_BYPASS_EN`.
- Defined: when the queue is empty and a non-discarded line returns, `dispatch_empty`=0 in the same cycle R+L.
  - `dispatch_inst` is taken from `icache_dout` at offset `read_offset`.
  - A pop in that cycle consumes that word; the remainder of the line is still written.
- Undefined: no combinational path from `icache_*` to `dispatch_*`; data becomes visible one cycle later as specified above.

## Test plan

1. **Reset and sequential fetch.** Reset, release, icache latency 2, memory returns word = address. Required:
   - request at addr 0x0;
   - `dispatch_empty` falls at cycle 4;
   - pops yield inst 0x0,0x4,0x8,0xC with `dispatch_pc_out` 0x4…0x10;
   - next request at 0x10.
2. **Full stall.** Never pop. Required: exactly `DEPTH_LINES` requests (0x0–0x30), then `icache_rd_en` stays 0. One pop of 4 words → single request at 0x40 the following cycle.
3. **Unaligned redirect.** Redirect to 0x1008. Required:
   - queue empties next cycle;
   - request at 0x1000;
   - first inst 0x1008 with `dispatch_pc_out` 0x100C, then 0x100C;
   - then a request at 0x1010.
4. **Redirect with request in flight.** Latency 3, redirect to 0x200 one cycle after a request to 0x40. Required:
   - 0x40 line is dropped;
   - request 0x200 issues only after that line returns;
   - head inst 0x200.
5. **Simultaneous events.** Redirect, `dispatch_rd_en`, and `icache_dout_valid` all in the same cycle. Required: no pop, line dropped, empty next cycle. Also: `dispatch_rd_en` while empty causes no pointer change.
6. **Bypass** (with `IFQ_BYPASS_EN`). Empty queue, line returns in cycle R. Required: `dispatch_empty`=0 and inst correct in R. Without the macro: in R+1.
